// File: rtl/demo004_pkg.sv
// Shared byte encoding and default sizing for the demo004 producer/consumer pair.
package demo004_pkg;

    localparam logic [7:0] BYTE_LOW  = 8'h00;
    localparam int         HIGH_FLAG = 7;
    localparam int         SEQ_W     = 7;

    localparam int DEFAULT_DEBOUNCE_CYCLES  = 16;
    localparam int DEFAULT_FIFO_DEPTH       = 4;
    localparam int DEFAULT_HEARTBEAT_CYCLES = 1024;

    typedef logic [SEQ_W-1:0] seq_t;

    // Byte reported while the debounced level is high: flag bit plus sequence number.
    function automatic logic [7:0] high_byte(input seq_t seq);
        logic [7:0] b;
        b               = BYTE_LOW;
        b[HIGH_FLAG]    = 1'b1;
        b[SEQ_W-1:0]    = seq;
        return b;
    endfunction

endpackage

// File: rtl/demo004_debounce.sv
// Two-flop synchronizer and debouncer for an asynchronous level input.
// Emits the accepted level plus one-cycle rise/fall pulses aligned with its changes.
module demo004_debounce
    import demo004_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic aclk,
    input  logic areset,
    input  logic btn_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] stable_cnt;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (areset) begin
            sync_q1    <= 1'b0;
            sync_q2    <= 1'b0;
            level      <= 1'b0;
            stable_cnt <= '0;
            rise       <= 1'b0;
            fall       <= 1'b0;
        end else begin
            sync_q1 <= btn_in;
            sync_q2 <= sync_q1;
            rise    <= 1'b0;
            fall    <= 1'b0;
            // Any sample that matches the current level restarts the stability window.
            if (sync_q2 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                level      <= sync_q2;
                stable_cnt <= '0;
                rise       <= sync_q2;
                fall       <= !sync_q2;
            end else begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/demo004_producer.sv
// Debounced button event producer feeding an AXI-Stream byte FIFO with sticky overflow.
// Optional periodic level heartbeat: define DEMO004_PRODUCER_HEARTBEAT_EN.
module demo004_producer
    import demo004_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = DEFAULT_DEBOUNCE_CYCLES,
    parameter int FIFO_DEPTH       = DEFAULT_FIFO_DEPTH,
    parameter int HEARTBEAT_CYCLES = DEFAULT_HEARTBEAT_CYCLES
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       btn_in,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        DEBOUNCE_CYCLES < 1 || HEARTBEAT_CYCLES < 2) begin : g_bad_params
        $error("demo004_producer: illegal parameter combination");
    end

    logic level;
    logic rise;
    logic fall;

    demo004_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .aclk   (aclk),
        .areset (areset),
        .btn_in (btn_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    seq_t          seq;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occupancy;
    logic [AW:0]   occupancy_next;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic [7:0]    push_byte;

`ifdef DEMO004_PRODUCER_HEARTBEAT_EN
    localparam int               HB_W    = $clog2(HEARTBEAT_CYCLES);
    localparam logic [HB_W-1:0]  HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);

    logic [HB_W-1:0] hb_cnt;
    logic            hb_due;

    assign hb_due = (hb_cnt == HB_LAST);

    // Events and heartbeats both restart the period; an event wins a tie.
    always_ff @(posedge aclk) begin
        if (areset) begin
            hb_cnt <= '0;
        end else if (rise || fall || hb_due) begin
            hb_cnt <= '0;
        end else begin
            hb_cnt <= hb_cnt + HB_W'(1);
        end
    end

    assign push_req = rise || fall || hb_due;
`else
    assign push_req = rise || fall;
`endif

    // rise/fall pulse together with the new level, so one encoding covers events and heartbeats.
    assign push_byte     = level ? high_byte(seq) : BYTE_LOW;
    assign full          = (occupancy == (AW+1)'(FIFO_DEPTH));
    assign m_axis_tvalid = (occupancy != '0);
    assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr] : BYTE_LOW;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign push_ok       = push_req && (!full || pop);

    always_comb begin
        // NOTE: default first so every path assigns occupancy_next and no latch is inferred.
        occupancy_next = occupancy;
        if (push_ok && !pop) begin
            occupancy_next = occupancy + (AW+1)'(1);
        end else if (pop && !push_ok) begin
            occupancy_next = occupancy - (AW+1)'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            seq       <= '0;
            overflow  <= 1'b0;
        end else begin
            occupancy <= occupancy_next;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Dropped rising events still consume a sequence number.
            if (rise) begin
                seq <= seq + SEQ_W'(1);
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // NOTE: storage is not reset; emptiness is tracked by occupancy and tdata is gated when empty.
    always_ff @(posedge aclk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_byte;
        end
    end

endmodule

// File: tb/tb_demo004_producer.sv
// Self-checking bench for demo004_producer: directed scenarios, a pulse-length table
// and randomized stimulus compared against a sample-history/queue reference model.
module tb_demo004_producer;

    localparam int D     = 16;
    localparam int DEPTH = 4;
    localparam int HB    = 64;

    logic       aclk          = 1'b0;
    logic       areset        = 1'b1;
    logic       btn_in        = 1'b0;
    logic       m_axis_tready = 1'b0;
    logic       m_axis_tvalid;
    logic [7:0] m_axis_tdata;
    logic       overflow;

    int n_pass   = 0;
    int n_checks = 0;
    int cyc      = 0;

    demo004_producer #(
        .DEBOUNCE_CYCLES  (D),
        .FIFO_DEPTH       (DEPTH),
        .HEARTBEAT_CYCLES (HB)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .btn_in        (btn_in),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .overflow      (overflow)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: raw input history, debounced level, byte queue, sticky overflow.
    bit         m_samp[$];
    bit         m_lvl;
    bit [6:0]   m_seq;
    logic [7:0] m_q[$];
    bit         m_ovf;
    int         m_pend;     // 0 none, 1 rising event, 2 falling event (pushed next edge)
    int         m_hb;
    bit         m_ready = 1'b0;

    logic [7:0] obs[$];
    int         obs_cyc[$];

    task automatic model_step();
        logic [7:0] pbyte;
        bit         has_push;
        bit         pop;
        bit         all_diff;
        int         n;
        if (areset) begin
            m_samp.delete();
            m_samp.push_back(1'b0);
            m_samp.push_back(1'b0);
            m_lvl   = 1'b0;
            m_seq   = '0;
            m_q.delete();
            m_ovf   = 1'b0;
            m_pend  = 0;
            m_hb    = 0;
            m_ready = 1'b1;
            return;
        end
        if (!m_ready) return;
        pop      = m_axis_tready && (m_q.size() != 0);
        has_push = (m_pend != 0);
        pbyte    = (m_pend == 1) ? {1'b1, m_seq} : 8'h00;
        if (m_pend == 1) m_seq++;
`ifdef DEMO004_PRODUCER_HEARTBEAT_EN
        if (m_pend != 0) m_hb = 0;
        else if (m_hb == HB - 1) begin
            m_hb     = 0;
            has_push = 1'b1;
            pbyte    = m_lvl ? {1'b1, m_seq} : 8'h00;
        end else m_hb++;
`endif
        if (pop) void'(m_q.pop_front());
        if (has_push) begin
            if (m_q.size() < DEPTH) m_q.push_back(pbyte);
            else m_ovf = 1'b1;
        end
        // Level flips once the D synchronized samples (two cycles old) all disagree with it.
        m_samp.push_back(btn_in);
        m_pend = 0;
        n = m_samp.size();
        if (n >= D + 2) begin
            all_diff = 1'b1;
            for (int i = 0; i < D; i++) if (m_samp[n-3-i] == m_lvl) all_diff = 1'b0;
            if (all_diff) begin
                m_lvl  = !m_lvl;
                m_pend = m_lvl ? 1 : 2;
            end
        end
        if (n > D + 4) void'(m_samp.pop_front());
    endtask

    task automatic monitor_step();
        if (!m_ready) return;
        check("tvalid", m_axis_tvalid, m_q.size() != 0);
        if (m_q.size() != 0) check("tdata", m_axis_tdata, m_q[0]);
        check("overflow", overflow, m_ovf);
        if (!areset && m_axis_tvalid && m_axis_tready) begin
            obs.push_back(m_axis_tdata);
            obs_cyc.push_back(cyc);
        end
    endtask

    initial forever begin
        @(posedge aclk);
        cyc++;
        model_step();
    end

    initial forever begin
        @(negedge aclk);
        #1;
        monitor_step();
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
    endtask

    typedef struct {
        int unsigned pulse_len;
        int unsigned exp_count;
        logic [7:0]  exp_first;
        logic [7:0]  exp_last;
    } pulse_vec_t;

    pulse_vec_t vecs[5];
    logic [7:0] exp4[4];
    logic [7:0] hi[$];
    int         p_next;

    initial begin
        vecs[0] = '{1,  0, 8'h00, 8'h00};
        vecs[1] = '{5,  0, 8'h00, 8'h00};
        vecs[2] = '{15, 0, 8'h00, 8'h00};
        vecs[3] = '{16, 2, 8'h80, 8'h00};
        vecs[4] = '{40, 2, 8'h80, 8'h00};
        exp4    = '{8'h80, 8'h00, 8'h81, 8'h00};

        @(negedge aclk);
        check("reset_tvalid", m_axis_tvalid, 1'b0);
        check("reset_tdata", m_axis_tdata, 8'h00);
        check("reset_overflow", overflow, 1'b0);
        areset = 1'b0;

`ifndef DEMO004_PRODUCER_HEARTBEAT_EN
        // Rising edge latency: 2 sync + D debounce + 1 push cycle.
        m_axis_tready = 1'b1;
        tick(5);
        obs.delete();
        btn_in = 1'b1;
        tick(D + 2);
        check("latency_early", m_axis_tvalid, 1'b0);
        tick(1);
        check("latency_tvalid", m_axis_tvalid, 1'b1);
        check("latency_tdata", m_axis_tdata, 8'h80);
        tick(40 - D - 3);
        check("hold_count", obs.size(), 1);
        if (obs.size() == 1) check("hold_byte", obs[0], 8'h80);
        btn_in = 1'b0;
        tick(D + 8);

        // Pulse-length table.
        foreach (vecs[v]) begin
            btn_in = 1'b0;
            do_reset();
            tick(3);
            obs.delete();
            btn_in = 1'b1;
            tick(vecs[v].pulse_len);
            btn_in = 1'b0;
            tick(D + 10);
            check($sformatf("pulse%0d_count", vecs[v].pulse_len), obs.size(), vecs[v].exp_count);
            if (vecs[v].exp_count > 0 && obs.size() == vecs[v].exp_count) begin
                check($sformatf("pulse%0d_first", vecs[v].pulse_len), obs[0], vecs[v].exp_first);
                check($sformatf("pulse%0d_last", vecs[v].pulse_len), obs[obs.size()-1], vecs[v].exp_last);
            end
        end

        // Backpressure: six toggles into a 4-deep FIFO.
        m_axis_tready = 1'b0;
        do_reset();
        for (int t = 0; t < 6; t++) begin
            btn_in = !btn_in;
            tick(D + 6);
        end
        check("full_overflow", overflow, 1'b1);
        check("full_tvalid", m_axis_tvalid, 1'b1);
        check("full_head", m_axis_tdata, 8'h80);
        obs.delete();
        m_axis_tready = 1'b1;
        tick(8);
        check("drain_count", obs.size(), 4);
        if (obs.size() == 4)
            for (int k = 0; k < 4; k++) check($sformatf("drain_byte%0d", k), obs[k], exp4[k]);
        check("drain_overflow_sticky", overflow, 1'b1);

        // Reset while a byte is stalled.
        m_axis_tready = 1'b0;
        for (int t = 0; t < 2; t++) begin
            btn_in = !btn_in;
            tick(D + 6);
        end
        check("stall_tvalid", m_axis_tvalid, 1'b1);
        check("stall_head", m_axis_tdata, 8'h83);
        areset = 1'b1;
        tick(1);
        check("midreset_tvalid", m_axis_tvalid, 1'b0);
        check("midreset_tdata", m_axis_tdata, 8'h00);
        check("midreset_overflow", overflow, 1'b0);
        areset = 1'b0;
        m_axis_tready = 1'b1;
        obs.delete();
        tick(D + 6);
        check("post_reset_quiet", obs.size(), 0);

        // Sequence wrap over 130 rising events.
        do_reset();
        obs.delete();
        for (int t = 0; t < 130; t++) begin
            btn_in = 1'b1;
            tick(D + 5);
            btn_in = 1'b0;
            tick(D + 5);
        end
        hi.delete();
        foreach (obs[k]) if (obs[k][7]) hi.push_back(obs[k]);
        check("wrap_count", hi.size(), 130);
        if (hi.size() == 130) begin
            check("wrap_first", hi[0], 8'h80);
            check("wrap_127", hi[127], 8'hFF);
            check("wrap_128", hi[128], 8'h80);
            check("wrap_129", hi[129], 8'h81);
        end
`endif

        // Input held high through reset release yields a rising event.
        m_axis_tready = 1'b1;
        @(negedge aclk);
        btn_in = 1'b1;
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        obs.delete();
        tick(D + 8);
        check("held_count", obs.size(), 1);
        if (obs.size() == 1) check("held_byte", obs[0], 8'h80);

`ifdef DEMO004_PRODUCER_HEARTBEAT_EN
        btn_in = 1'b0;
        do_reset();
        obs.delete();
        tick(3 * HB + 4);
        check("hb_count", obs.size(), 3);
        if (obs.size() == 3) begin
            for (int k = 0; k < 3; k++) check("hb_byte", obs[k], 8'h00);
            check("hb_period1", obs_cyc[1] - obs_cyc[0], HB);
            check("hb_period2", obs_cyc[2] - obs_cyc[1], HB);
            // Land a rising event exactly on the next heartbeat edge.
            p_next = obs_cyc[2] + HB;
            while (cyc < p_next - D - 3) @(negedge aclk);
            btn_in = 1'b1;
            obs.delete();
            while (cyc < p_next + 2) @(negedge aclk);
            check("hb_tie_count", obs.size(), 1);
            if (obs.size() == 1) begin
                check("hb_tie_byte", obs[0], 8'h80);
                check("hb_tie_cycle", obs_cyc[0], p_next);
            end
            while (cyc < p_next + HB + 2) @(negedge aclk);
            check("hb_high_count", obs.size(), 2);
            if (obs.size() == 2) begin
                check("hb_high_byte", obs[1], 8'h81);
                check("hb_restart", obs_cyc[1] - obs_cyc[0], HB);
            end
        end
`endif

        // Randomized phase: held levels of random length, bursty ready, rare resets.
        btn_in = 1'b0;
        do_reset();
        for (int seg = 0; seg < 250; seg++) begin
            int len;
            len    = $urandom_range(1, 2 * D + 4);
            btn_in = 1'($urandom_range(0, 1));
            for (int j = 0; j < len; j++) begin
                @(negedge aclk);
                if ((seg % 50) < 25) m_axis_tready = ($urandom_range(0, 7) != 0);
                else                 m_axis_tready = ($urandom_range(0, 7) == 0);
                areset = ($urandom_range(0, 499) == 0);
            end
        end
        areset = 1'b0;
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
